// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the sys_ctrl command sequencer and the sys datapath.
package sys_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] ADD    = 2'b00;
    localparam logic [OP_W-1:0] SUB    = 2'b01;
    localparam logic [OP_W-1:0] SHIFTL = 2'b10;
    localparam logic [OP_W-1:0] SHIFTR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        EXEC,
        CAPT,
        WB
    } state_t;

endpackage

// File: rtl/sys.sv
// sys datapath: 32x32 register file with registered reads feeding a registered ALU.
// The register file has no reset, so stored values survive a controller reset.
module sys
    import sys_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              wenable,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [ADDR_W-1:0] address3,
    input  logic [DATA_W-1:0] inpmain,
    output logic [DATA_W-1:0] result
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int SH_W  = $clog2(DATA_W);

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] alu_next;
    logic              shift_oor;

    // Any set bit above the shift-amount field means B >= DATA_W.
    assign shift_oor = |b_reg[DATA_W-1:SH_W];

    always_comb begin
        alu_next = '0;
        case (opcode)
            ADD:     alu_next = a_reg + b_reg;
            SUB:     alu_next = a_reg - b_reg;
            SHIFTL:  alu_next = shift_oor ? '0 : (a_reg << b_reg[SH_W-1:0]);
            default: alu_next = shift_oor ? '0 : (a_reg >> b_reg[SH_W-1:0]);
        endcase
    end

    always_ff @(posedge clock) begin
        if (wenable) begin
            regs[address3] <= inpmain;
        end
        a_reg      <= regs[address1];
        b_reg      <= regs[address2];
        result_reg <= alu_next;
    end

    assign result = result_reg;

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer driving the sys datapath through its read/execute latency.
// Optional completed-command counter op_count is enabled with SYS_CTRL_STATS_EN.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_a1,
    input  logic [ADDR_W-1:0] cmd_a2,
    input  logic [ADDR_W-1:0] cmd_a3,
    input  logic              cmd_wb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              wenable,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] address1,
    output logic [ADDR_W-1:0] address2,
    output logic [ADDR_W-1:0] address3,
    output logic [DATA_W-1:0] inpmain,
    input  logic [DATA_W-1:0] result,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
`ifdef SYS_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  op_count
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sys_ctrl: CNT_W must be at least 1");
    end

    state_t state_reg, state_next;

    logic              accept;
    logic              rd_phase;
    logic              wr_phase;
    logic [DATA_W-1:0] wr_data;

    // Command fields captured at accept.
    logic [OP_W-1:0]   op_reg;
    logic [ADDR_W-1:0] a1_reg, a2_reg, a3_reg;
    logic              wb_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [DATA_W-1:0] res_reg;

    // Last values driven to the datapath, replayed while the phase that owns them is inactive.
    logic [OP_W-1:0]   op_hold_reg;
    logic [ADDR_W-1:0] a1_hold_reg, a2_hold_reg, a3_hold_reg;
    logic [DATA_W-1:0] din_hold_reg;

    assign cmd_ready = (state_reg == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = cmd_load ? LOAD : READ;
            LOAD:    state_next = IDLE;
            READ:    state_next = EXEC;
            EXEC:    state_next = CAPT;
            CAPT:    state_next = wb_reg ? WB : IDLE;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rd_phase = (state_reg == READ) || (state_reg == EXEC) || (state_reg == CAPT);
    assign wr_phase = (state_reg == LOAD) || (state_reg == WB);
    assign wr_data  = (state_reg == LOAD) ? imm_reg : res_reg;

    assign wenable   = wr_phase && !reset;
    assign opcode    = rd_phase ? op_reg  : op_hold_reg;
    assign address1  = rd_phase ? a1_reg  : a1_hold_reg;
    assign address2  = rd_phase ? a2_reg  : a2_hold_reg;
    assign address3  = wr_phase ? a3_reg  : a3_hold_reg;
    assign inpmain   = wr_phase ? wr_data : din_hold_reg;

    // The datapath result is already registered, so it is shown directly during the pulse.
    assign rsp_valid = (state_reg == CAPT) && !reset;
    assign rsp_data  = (state_reg == CAPT) ? result : res_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            a1_reg       <= '0;
            a2_reg       <= '0;
            a3_reg       <= '0;
            wb_reg       <= 1'b0;
            imm_reg      <= '0;
            res_reg      <= '0;
            op_hold_reg  <= '0;
            a1_hold_reg  <= '0;
            a2_hold_reg  <= '0;
            a3_hold_reg  <= '0;
            din_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= cmd_op;
                a1_reg  <= cmd_a1;
                a2_reg  <= cmd_a2;
                a3_reg  <= cmd_a3;
                wb_reg  <= cmd_wb;
                imm_reg <= cmd_imm;
            end
            if (state_reg == CAPT) begin
                res_reg <= result;
            end
            if (rd_phase) begin
                op_hold_reg <= op_reg;
                a1_hold_reg <= a1_reg;
                a2_hold_reg <= a2_reg;
            end
            if (wr_phase) begin
                a3_hold_reg  <= a3_reg;
                din_hold_reg <= wr_data;
            end
        end
    end

`ifdef SYS_CTRL_STATS_EN
    logic [CNT_W-1:0] cnt_reg;

    // A command completes at the end of LOAD, or at the end of CAPT for ALU commands.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (((state_reg == LOAD) || (state_reg == CAPT)) && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign op_count = cnt_reg;
`endif

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl driving the sys datapath; op_count is checked when SYS_CTRL_STATS_EN is defined.
module tb_sys_ctrl;
    import sys_ctrl_pkg::*;

`ifdef SYS_CTRL_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic        clock, reset;
    logic        cmd_valid, cmd_ready, cmd_load, cmd_wb;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_a1, cmd_a2, cmd_a3;
    logic [31:0] cmd_imm;
    logic        wenable, rsp_valid, busy;
    logic [1:0]  opcode;
    logic [4:0]  address1, address2, address3;
    logic [31:0] inpmain, result, rsp_data;
`ifdef SYS_CTRL_STATS_EN
    logic [CW-1:0] op_count;
`endif

    sys_ctrl #(.CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_op(cmd_op),
        .cmd_a1(cmd_a1), .cmd_a2(cmd_a2), .cmd_a3(cmd_a3), .cmd_wb(cmd_wb), .cmd_imm(cmd_imm),
        .wenable(wenable), .opcode(opcode), .address1(address1), .address2(address2),
        .address3(address3), .inpmain(inpmain), .result(result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
`ifdef SYS_CTRL_STATS_EN
        , .op_count(op_count)
`endif
    );

    sys dp (
        .clock(clock), .wenable(wenable), .opcode(opcode), .address1(address1),
        .address2(address2), .address3(address3), .inpmain(inpmain), .result(result)
    );

    typedef struct { logic [31:0] data; int cyc; } rsp_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wr_t;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [31:0] rf [32];
    logic [31:0] last_rsp;
    int          total, bad, cyc;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            SHIFTL:  return (b >= 32) ? 32'h0 : (a << b);
            default: return (b >= 32) ? 32'h0 : (a >> b);
        endcase
    endfunction

    // Monitor: every response pulse and every datapath write must match the next queued expectation.
    always @(negedge clock) begin
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check_eq("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check_eq("rsp_data", rsp_data, e.data);
                check_eq("rsp_cycle", cyc, e.cyc);
                last_rsp = e.data;
                $display("rsp  data=%h cycle=%0d", rsp_data, cyc);
            end
        end else begin
            check_eq("rsp_hold", rsp_data, last_rsp);
        end
        if (wenable === 1'b1) begin
            if (wr_q.size() == 0) begin
                check_eq("wr_unexpected", {31'b0, wenable}, 32'h0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check_eq("wr_addr", {27'b0, address3}, {27'b0, w.addr});
                check_eq("wr_data", inpmain, w.data);
                check_eq("wr_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic scramble();
        cmd_load = 1'($urandom);
        cmd_op   = 2'($urandom);
        cmd_a1   = 5'($urandom);
        cmd_a2   = 5'($urandom);
        cmd_a3   = 5'($urandom);
        cmd_wb   = 1'($urandom);
        cmd_imm  = $urandom;
    endtask

    // abort_at > 0: reset is raised that many edges after accept (1 = during EXEC, 3 = during WB).
    task automatic send(input bit ld, input logic [1:0] op, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input bit wb, input logic [31:0] imm,
                        input bit hold, input int abort_at);
        int w;
        int acc;
        int n;
        logic [31:0] r;
        cmd_load = ld; cmd_op = op; cmd_a1 = a1; cmd_a2 = a2; cmd_a3 = a3;
        cmd_wb = wb; cmd_imm = imm; cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            check_eq("accept_timeout", {31'b0, cmd_ready}, 32'h1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        acc = cyc;
        if (ld) begin
            if (abort_at == 0) begin
                wr_q.push_back('{addr: a3, data: imm, cyc: acc});
                rf[a3] = imm;
            end
            $display("cmd  LOAD r%0d=%h cycle=%0d", a3, imm, acc);
        end else begin
            r = alu_ref(op, rf[a1], rf[a2]);
            if (abort_at == 0 || abort_at >= 3) rsp_q.push_back('{data: r, cyc: acc + 2});
            if (wb && abort_at == 0) begin
                wr_q.push_back('{addr: a3, data: r, cyc: acc + 3});
                rf[a3] = r;
            end
            $display("cmd  op=%0d a1=%0d a2=%0d wb=%0d a3=%0d expect=%h cycle=%0d abort=%0d",
                     op, a1, a2, wb, a3, r, acc, abort_at);
        end
        if (!hold) begin
            cmd_valid = 1'b0;
            scramble();
        end
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clock);
            #1 reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
            last_rsp = 32'h0;
            @(negedge clock);
            check_eq("ready_after_rst", {31'b0, cmd_ready}, 32'h1);
            check_eq("busy_after_rst", {31'b0, busy}, 32'h0);
            return;
        end
        n = ld ? 1 : (wb ? 4 : 3);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check_eq("ready_busy", {31'b0, cmd_ready}, 32'h0);
        end
        @(negedge clock);
        check_eq("ready_idle", {31'b0, cmd_ready}, 32'h1);
    endtask

    task automatic load(input logic [4:0] a3, input logic [31:0] imm);
        send(1'b1, 2'b00, 5'd0, 5'd0, a3, 1'b0, imm, 1'b0, 0);
    endtask

    task automatic alu(input logic [1:0] op, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input bit wb);
        send(1'b0, op, a1, a2, a3, wb, 32'h0, 1'b0, 0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; last_rsp = 32'h0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        reset = 1'b1; cmd_valid = 1'b0;
        cmd_load = 1'b0; cmd_op = 2'b00; cmd_a1 = '0; cmd_a2 = '0; cmd_a3 = '0;
        cmd_wb = 1'b0; cmd_imm = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_ready", {31'b0, cmd_ready}, 32'h0);
        check_eq("rst_wenable", {31'b0, wenable}, 32'h0);
        check_eq("rst_opcode", {30'b0, opcode}, 32'h0);
        check_eq("rst_address1", {27'b0, address1}, 32'h0);
        check_eq("rst_address2", {27'b0, address2}, 32'h0);
        check_eq("rst_address3", {27'b0, address3}, 32'h0);
        check_eq("rst_inpmain", inpmain, 32'h0);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        check_eq("rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        #1 check_eq("ready_out_of_rst", {31'b0, cmd_ready}, 32'h1);

        // Basic add.
        load(5'd1, 32'd5); load(5'd2, 32'd3); load(5'd0, 32'd0);
        alu(ADD, 5'd1, 5'd2, 5'd0, 1'b0);

        // Subtract with write-back, then observe the written register.
        load(5'd1, 32'd3); load(5'd2, 32'd5);
        alu(SUB, 5'd1, 5'd2, 5'd4, 1'b1);
        alu(ADD, 5'd4, 5'd0, 5'd0, 1'b0);

        // Shifts, including an out-of-range amount.
        load(5'd1, 32'd1); load(5'd2, 32'd4);
        alu(SHIFTL, 5'd1, 5'd2, 5'd0, 1'b0);
        load(5'd1, 32'h8000_0000); load(5'd2, 32'd31);
        alu(SHIFTR, 5'd1, 5'd2, 5'd0, 1'b0);
        load(5'd2, 32'd32);
        alu(SHIFTL, 5'd1, 5'd2, 5'd0, 1'b0);

        // Back-to-back with cmd_valid held high.
        send(1'b0, ADD, 5'd1, 5'd1, 5'd7, 1'b1, 32'h0, 1'b1, 0);
        send(1'b0, SUB, 5'd7, 5'd2, 5'd8, 1'b0, 32'h0, 1'b1, 0);
        send(1'b1, ADD, 5'd0, 5'd0, 5'd9, 1'b0, 32'h1234_5678, 1'b0, 0);
        alu(ADD, 5'd9, 5'd7, 5'd0, 1'b0);

        // Reset during EXEC and during WB: target register must keep its old value.
        load(5'd5, 32'hAAAA_0005);
        send(1'b0, ADD, 5'd1, 5'd2, 5'd5, 1'b1, 32'h0, 1'b0, 1);
        alu(ADD, 5'd5, 5'd0, 5'd0, 1'b0);
        load(5'd6, 32'hBBBB_0006);
        send(1'b0, SUB, 5'd1, 5'd2, 5'd6, 1'b1, 32'h0, 1'b0, 3);
        alu(ADD, 5'd6, 5'd0, 5'd0, 1'b0);

        // Randomized traffic over a fully initialised register file.
        for (int i = 0; i < 32; i++) load(5'(i), $urandom);
        for (int i = 0; i < 40; i++) begin
            bit          hold;
            logic [31:0] imm;
            hold = (i == 39) ? 1'b0 : 1'($urandom);
            imm  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 4) == 0)
                send(1'b1, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), imm, hold, 0);
            else
                send(1'b0, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), imm, hold, 0);
        end

`ifdef SYS_CTRL_STATS_EN
        check_eq("op_count_sat", {30'b0, op_count}, 32'd3);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0; last_rsp = 32'h0;
        @(negedge clock);
        check_eq("op_count_rst", {30'b0, op_count}, 32'd0);
        load(5'd10, 32'd1);
        alu(ADD, 5'd10, 5'd10, 5'd0, 1'b0);
        check_eq("op_count_two", {30'b0, op_count}, 32'd2);
        load(5'd11, 32'd2);
        alu(ADD, 5'd11, 5'd10, 5'd12, 1'b1);
        load(5'd13, 32'd3);
        check_eq("op_count_five", {30'b0, op_count}, 32'd3);
`endif

        repeat (8) @(negedge clock);
        check_eq("rsp_queue_drain", rsp_q.size(), 32'd0);
        check_eq("wr_queue_drain", wr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
